// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the write-port arbiter's request record, defaults
// and selection encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // One register-file write: destination register and data.
  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } wb_req_t;

  localparam int unsigned WB_BUF_DEPTH    = 32'd2;
  localparam int unsigned WB_STARVE_LIMIT = 32'd8;

  // Which source owns the register-file write slot this cycle.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_WB   = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

  // One-hot register mask used to build the pending-write vector.
  function automatic word_t reg_onehot(input regbits_t r);
    reg_onehot = 32'h0000_0001 << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO for long-latency results. Besides push/pop it exposes
// every slot with a valid bit so the arbiter can build the pending mask.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = WB_BUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 32'd1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                push_i,
  input  wb_req_t             push_data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [CNT_W-1:0]    count_o,
  output wb_req_t             head_o,
  output wb_req_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]    valid_o
);

  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset drops every buffered entry.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mem_q    <= {(DEPTH * $bits(wb_req_t)){1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    valid_o = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback has priority; long-
// latency results queue in wb_fifo until a free write slot appears. The
// write port is driven from registers; pending flags buffered destinations.
// Optional starvation guard: compile with WB_ARB_STARVE_GUARD_EN.
module wb_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned BUF_DEPTH    = WB_BUF_DEPTH,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wsel,
  input  logic [31:0] wb_wdat,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_wsel,
  input  logic [31:0] ll_wdat,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat,
  output logic [31:0] pending,
  output logic        pipe_stall
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 32'd1;

  if ((BUF_DEPTH < 32'd2) || ((BUF_DEPTH & (BUF_DEPTH - 32'd1)) != 32'd0) ||
      (STARVE_LIMIT < 32'd1)) begin : g_param_check
    $error("wb_write_arbiter: BUF_DEPTH must be a power of 2 >= 2, STARVE_LIMIT >= 1");
  end

  logic                    store_s, pop_s, full_s, empty_s;
  logic [CNT_W-1:0]        count_s;
  wb_req_t                 ll_req_s, head_s;
  wb_req_t [BUF_DEPTH-1:0] entries_s;
  logic [BUF_DEPTH-1:0]    valid_s;
  logic                    wb_take_s, head_prio_s;
  wb_sel_e                 sel_s;
  logic                    wen_q, wen_d;
  regbits_t                wsel_q, wsel_d;
  word_t                   wdat_q, wdat_d;
  word_t                   pending_s;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign ll_ready      = (count_s < CNT_W'(BUF_DEPTH));
  // Writes to r0 complete the handshake but are never stored.
  assign store_s       = ll_valid && ll_ready && (ll_wsel != 5'd0);
  assign ll_req_s.wsel = ll_wsel;
  assign ll_req_s.wdat = ll_wdat;
  assign wb_take_s     = wb_valid && (wb_wsel != 5'd0);
  assign pop_s         = (sel_s == SEL_FIFO);

  wb_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .push_i     (store_s),
    .push_data_i(ll_req_s),
    .pop_i      (pop_s),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .count_o    (count_s),
    .head_o     (head_s),
    .entries_o  (entries_s),
    .valid_o    (valid_s)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 32'd1);

  logic [AGE_W-1:0] age_q, age_d;
  logic             stall_q, stall_d;

  // Age of the waiting head; stall is requested once it saturates.
  always_comb begin
    if (empty_s || pop_s) begin
      age_d = {AGE_W{1'b0}};
    end else if (age_q < AGE_W'(STARVE_LIMIT)) begin
      age_d = age_q + AGE_W'(1'b1);
    end else begin
      age_d = age_q;
    end
    stall_d = (age_d == AGE_W'(STARVE_LIMIT));
  end

  // Guard state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      age_q   <= {AGE_W{1'b0}};
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  assign head_prio_s = stall_q;
  assign pipe_stall  = stall_q;
`else
  assign head_prio_s = 1'b0;
  assign pipe_stall  = 1'b0;
`endif

  // Pick the owner of the write slot: a stalled head, then wb, then FIFO.
  always_comb begin
    sel_s = SEL_IDLE;
    if (head_prio_s && !empty_s) begin
      sel_s = SEL_FIFO;
    end else if (wb_take_s) begin
      sel_s = SEL_WB;
    end else if (!empty_s) begin
      sel_s = SEL_FIFO;
    end else begin
      sel_s = SEL_IDLE;
    end
  end

  // Next write-port value; an idle cycle keeps wsel/wdat as they were.
  always_comb begin
    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    case (sel_s)
      SEL_WB: begin
        wen_d  = 1'b1;
        wsel_d = wb_wsel;
        wdat_d = wb_wdat;
      end
      SEL_FIFO: begin
        wen_d  = 1'b1;
        wsel_d = head_s.wsel;
        wdat_d = head_s.wdat;
      end
      default: begin
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
      end
    endcase
  end

  // Registered register-file write port.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wen_q  <= 1'b0;
      wsel_q <= 5'd0;
      wdat_q <= 32'd0;
    end else begin
      wen_q  <= wen_d;
      wsel_q <= wsel_d;
      wdat_q <= wdat_d;
    end
  end

  // Pending mask: every destination still sitting in the FIFO.
  always_comb begin
    pending_s = 32'd0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (valid_s[i]) begin
        pending_s = pending_s | reg_onehot(entries_s[i].wsel);
      end else begin
        pending_s = pending_s;
      end
    end
  end

  assign WEN     = wen_q;
  assign wsel    = wsel_q;
  assign wdat    = wdat_q;
  assign pending = pending_s;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: the driver runs a queue-based
// reference model and pushes every expected register-file write; a monitor
// on the falling edge pops and compares whenever WEN is presented.
module tb_wb_write_arbiter;
  import cpu_types_pkg::*;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_wsel = 5'd0;
  logic [31:0] wb_wdat = 32'd0;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_wsel = 5'd0;
  logic [31:0] ll_wdat = 32'd0;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [31:0] pending;
  logic        pipe_stall;

  int n_tests = 0;
  int n_fail  = 0;

  wb_req_t  exp_q[$];   // writes the register file must see, in order
  wb_req_t  mdl_q[$];   // model of the long-latency buffer
  regbits_t last_wsel = 5'd0;
  word_t    last_wdat = 32'd0;

  wb_write_arbiter #(.BUF_DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(wb_valid), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wsel(ll_wsel), .ll_wdat(ll_wdat),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .pending(pending), .pipe_stall(pipe_stall)
  );

  always #5 CLK = ~CLK;

`ifdef WB_ARB_STARVE_GUARD_EN
  a_no_wb_in_stall: assert property (@(posedge CLK) disable iff (!nRST) pipe_stall |-> !wb_valid)
    else $error("FAIL wb_valid during pipe_stall");
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t model_pending();
    word_t m = 32'd0;
    foreach (mdl_q[i]) m = m | (32'h0000_0001 << mdl_q[i].wsel);
    return m;
  endfunction

  // Monitor: every presented write must be the next expected one.
  initial begin
    wb_req_t e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        last_wsel = 5'd0;
        last_wdat = 32'd0;
      end else if (WEN) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wen", {31'd0, WEN}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wsel", {27'd0, wsel}, {27'd0, e.wsel});
          chk("wdat", wdat, e.wdat);
          last_wsel = e.wsel;
          last_wdat = e.wdat;
        end
      end else begin
        chk("hold_wsel", {27'd0, wsel}, {27'd0, last_wsel});
        chk("hold_wdat", wdat, last_wdat);
      end
`ifndef WB_ARB_STARVE_GUARD_EN
      if (nRST) chk("pipe_stall_off", {31'd0, pipe_stall}, 32'd0);
`endif
    end
  end

  // One clock of stimulus: check state left by the last edge, drive inputs,
  // then advance the model by the arbitration rules.
  task automatic cycle(input bit wv, input regbits_t ws, input word_t wd,
                       input bit lv, input regbits_t ls, input word_t ld);
    bit      accept, stall_prio;
    wb_req_t r;
    @(negedge CLK); #1;
    nRST = 1'b1;
    chk("ll_ready", {31'd0, ll_ready}, {31'd0, (mdl_q.size() < DEPTH)});
    chk("pending", pending, model_pending());
    stall_prio = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
    if (pipe_stall) wv = 1'b0;
    stall_prio = pipe_stall && (mdl_q.size() > 0);
`endif
    wb_valid = wv; wb_wsel = ws; wb_wdat = wd;
    ll_valid = lv; ll_wsel = ls; ll_wdat = ld;
    accept = lv && (mdl_q.size() < DEPTH);
    if (stall_prio) begin
      exp_q.push_back(mdl_q.pop_front());
    end else if (wv && ws != 5'd0) begin
      r.wsel = ws; r.wdat = wd;
      exp_q.push_back(r);
    end else if (mdl_q.size() > 0) begin
      exp_q.push_back(mdl_q.pop_front());
    end
    if (accept && ls != 5'd0) begin
      r.wsel = ls; r.wdat = ld;
      mdl_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Check outputs just after the edge that follows the last cycle() call.
  task automatic expect_out(input string name, input bit wen, input regbits_t ws, input word_t wd);
    @(posedge CLK); #1;
    chk({name, "_wen"}, {31'd0, WEN}, {31'd0, wen});
    if (wen) begin
      chk({name, "_wsel"}, {27'd0, wsel}, {27'd0, ws});
      chk({name, "_wdat"}, wdat, wd);
    end
  endtask

  // Reset for n edges with random traffic on both inputs, then check state.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK); #1;
      nRST = 1'b0;
      wb_valid = 1'b1; wb_wsel = 5'($urandom_range(1, 31)); wb_wdat = $urandom;
      ll_valid = 1'b1; ll_wsel = 5'($urandom_range(1, 31)); ll_wdat = $urandom;
    end
    mdl_q.delete();
    @(negedge CLK); #1;
    chk("rst_wen", {31'd0, WEN}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_ll_ready", {31'd0, ll_ready}, 32'd1);
    nRST = 1'b1;
    wb_valid = 1'b0; ll_valid = 1'b0;
  endtask

  initial begin
    // Reset with traffic present.
    do_reset(2);

    // Pipeline write, then a dropped r0 request.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    expect_out("wb_basic", 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    expect_out("wb_r0", 1'b0, 5'd0, 32'd0);
    idle(2);

    // LL pushes for r7 and r9 during a wb burst.
    cycle(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd7, 32'h7777_0007);
    cycle(1'b1, 5'd2, 32'hA000_0002, 1'b1, 5'd9, 32'h9999_0009);
    @(posedge CLK); #1;
    chk("burst_pending", pending, 32'h0000_0280);
    chk("burst_ready", {31'd0, ll_ready}, 32'd0);
    cycle(1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd11, 32'hBBBB_000B);
    idle(4);
    chk("burst_drained", pending, 32'd0);

    // Full FIFO popping with ll_valid held: refused, then accepted.
    cycle(1'b1, 5'd1, 32'hC000_0001, 1'b1, 5'd4, 32'h4444_0004);
    cycle(1'b1, 5'd2, 32'hC000_0002, 1'b1, 5'd6, 32'h6666_0006);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888_0008);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888_0008);
    idle(4);

    // Mid-operation reset discards two buffered entries.
    cycle(1'b1, 5'd1, 32'hD000_0001, 1'b1, 5'd7, 32'h7070_0007);
    cycle(1'b1, 5'd2, 32'hD000_0002, 1'b1, 5'd9, 32'h9090_0009);
    do_reset(1);
    idle(4);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(6);
    @(negedge CLK); #1;
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
